bcd_event_counter: RTL and testbench
====================================

# bcd_event_counter

Parametrised multi-digit decimal event counter for the front-panel and telemetry path. It consumes single-cycle debounced up/down event pulses and keeps an N-digit BCD count with a matching binary shadow. It drives a time-multiplexed digit scan for the seven-segment LED driver and hands the binary value to the RS-232 transmitter through a coalescing start/busy handshake.

## Interface
- NUM_DIGITS, 8: decimal digits held, 2..8.
- CNT_W, 27: binary shadow width; must satisfy 2^CNT_W >= 10^NUM_DIGITS.
- WRAP, 1: 1 = modulo-10^NUM_DIGITS wrap; 0 = saturate at the top (all 9s) and bottom (0).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inc  in  1  count-up event, one-cycle pulse (debouncer button_up).
- dec  in  1  count-down event, one-cycle pulse.
- clear  in  1  synchronous clear to zero.
- scan_tick  in  1  one-cycle scan-advance strobe.
- tx_busy  in  1  transmitter busy.
- bcd  out  4*NUM_DIGITS  packed BCD count, digit 0 in [3:0].
- bin_count  out  CNT_W  binary equal of bcd.
- overflow  out  1  sticky; set on wrap or saturation, cleared by clear.
- scan_idx  out  $clog2(NUM_DIGITS)  digit currently shown.
- scan_val  out  4  BCD digit at scan_idx.
- scan_blank  out  1  digit is to be blanked.
- tx_start  out  1  one-cycle send request.
- tx_data  out  CNT_W  value to send; held stable from tx_start until the next tx_start.

## Operation
- Reset values: bcd 0, bin_count 0, overflow 0, scan_idx 0, tx_start 0, tx_data 0, pending 0.
- Priority per cycle:
  - clear: zero count, clear overflow, set pending.
  - inc and dec together: no change.
  - inc: +1.
  - dec: -1.
  - Otherwise: hold.
- Increment is a BCD ripple: digit k increments when all lower digits are 9, and those digits go to 0. Digits never hold values above 9.
- Top boundary, inc at all 9s:
  - WRAP=1: the count goes to 0 and overflow is set.
  - WRAP=0: the count holds and overflow is set.
- Bottom boundary, dec at 0:
  - WRAP=1: the count goes to all 9s and overflow is set.
  - WRAP=0: the count holds and overflow is set.
- bin_count is updated in the same cycle with the same rule, so bin_count == decimal(bcd) always.
- TX handshake:
  - Any count change, or clear, sets pending.
  - When pending=1, tx_busy=0 and tx_start was 0 last cycle: pulse tx_start, load tx_data with the current bin_count, and clear pending. If a new change lands in the same cycle, pending stays set.
  - Changes that arrive while busy coalesce into one send of the latest value.
  - A saturated no-change event does not set pending.
- Scan: on scan_tick, scan_idx goes +1 and wraps from NUM_DIGITS-1 to 0, including for non-power-of-2 counts. scan_val is combinational from registered bcd.
- Asserting rst_n low mid-operation clears everything asynchronously, including a pending send. Any tx_start in flight is dropped.

## Timing
- Event sampled at edge N: bcd, bin_count and overflow are valid after edge N.
- tx_start is asserted at edge N+1 at the earliest, and lasts one cycle.
- tx_start pulses are at least 2 cycles apart. The transmitter must raise tx_busy by the cycle after tx_start.
- scan_idx is updated one edge after scan_tick. scan_val and scan_blank follow in the same cycle, with zero added latency.
- Inputs are synchronous to clk; debouncing and synchronisation happen upstream.

## Configuration
- BCD_EVENT_COUNTER_LZ_BLANK_EN defined: scan_blank=1 when digit scan_idx and all higher digits are 0, except digit 0, which is never blanked. A zero count shows a single "0".
- Not defined: scan_blank is tied to 0 and every digit is shown.

## Structure
- Shared package bcd_counter_pkg holds:
  - typedef bcd_digit_t (4-bit).
  - Constants BCD_MAX=9 and BCD_ZERO=0.
  - Function bcd_all9(bcd, n) used by the counter and the bench.
- One sub-module, bcd_decade: a single digit with ports d_in, up, dn, carry_in, borrow_in, d_out, carry_out, borrow_out. The counter instantiates NUM_DIGITS of them in a generate chain, with the boundary and saturation logic at the top level.
- The scan mux, TX pending logic and overflow flag live in the top level.

## Test plan
- 1234 inc pulses from reset -> bcd=0x00001234, bin_count=1234, overflow=0.
- NUM_DIGITS=2:
  - WRAP=1, 99 then inc -> bcd=0x00 and overflow=1.
  - WRAP=1, 0 then dec -> bcd=0x99 and overflow=1.
  - WRAP=0, 99 then inc -> holds 0x99, overflow=1, no tx_start.
- inc and dec in the same cycle at count 500 -> count stays 500, pending not set.
- tx_busy held high while 5 incs arrive from 10, then released -> exactly one tx_start with tx_data=15, one cycle after release.
- NUM_DIGITS=6, 6 scan_ticks -> scan_idx sequence 1,2,3,4,5,0. With the LZ macro at count 42, scan_blank=1 for idx 2..5 and 0 for idx 0..1.
- rst_n low for 1 cycle while pending and count=77 -> all outputs 0 and no tx_start afterwards.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and helpers for the BCD event counter and its bench.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BCD_ZERO   = 4'd0;
  localparam int         MAX_DIGITS = 8;
  localparam int         ALL_W      = 4 * MAX_DIGITS;

  // True when the low n digits of a zero-extended packed BCD word are all 9.
  function automatic logic bcd_all9(input logic [ALL_W-1:0] bcd, input int n);
    logic all9;
    all9 = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (k < n && bcd[4*k +: 4] != BCD_MAX) all9 = 1'b0;
    return all9;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD digit of the ripple chain: steps when its lower neighbours carry or borrow into it.
module bcd_decade
  import bcd_counter_pkg::*;
(
  input  bcd_digit_t d_in,
  input  logic       up,
  input  logic       dn,
  input  logic       carry_in,
  input  logic       borrow_in,
  output bcd_digit_t d_out,
  output logic       carry_out,
  output logic       borrow_out
);

  logic w_step_up;
  logic w_step_dn;

  assign w_step_up  = up & carry_in;
  assign w_step_dn  = dn & borrow_in;
  assign carry_out  = w_step_up & (d_in == BCD_MAX);
  assign borrow_out = w_step_dn & (d_in == BCD_ZERO);

  // NOTE: d_out gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    d_out = d_in;
    if (w_step_up)      d_out = (d_in == BCD_MAX)  ? BCD_ZERO : d_in + 4'd1;
    else if (w_step_dn) d_out = (d_in == BCD_ZERO) ? BCD_MAX  : d_in - 4'd1;
  end

endmodule

// File: rtl/bcd_event_counter.sv
// N-digit BCD up/down event counter with binary shadow, digit scan and coalescing TX handshake.
// Optional leading-zero blanking of the scan output: define BCD_EVENT_COUNTER_LZ_BLANK_EN.
module bcd_event_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CNT_W      = 27,
  parameter bit WRAP       = 1'b1
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inc,
  input  logic                          dec,
  input  logic                          clear,
  input  logic                          scan_tick,
  input  logic                          tx_busy,
  output logic [4*NUM_DIGITS-1:0]       bcd,
  output logic [CNT_W-1:0]              bin_count,
  output logic                          overflow,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output bcd_digit_t                    scan_val,
  output logic                          scan_blank,
  output logic                          tx_start,
  output logic [CNT_W-1:0]              tx_data
);

  localparam int                BCD_W     = 4 * NUM_DIGITS;
  localparam int                SCAN_W    = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  BIN_MAX   = CNT_W'(pow10(NUM_DIGITS) - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_bcd_step;
  logic [CNT_W-1:0]  r_bin;
  logic [CNT_W-1:0]  w_bin_next;
  logic [CNT_W-1:0]  r_tx_data;
  logic [SCAN_W-1:0] r_scan_idx;
  logic              r_ovf;
  logic              r_pending;
  logic              r_tx_start;
  logic              w_up;
  logic              w_dn;
  logic              w_ovf_evt;
  logic              w_hold;
  logic              w_change;
  logic              w_send;

  assign w_up = inc & ~dec;
  assign w_dn = dec & ~inc;

  // Per-digit chain signals live in each generate scope so the ripple is not one looped vector.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic w_carry_in, w_borrow_in, w_carry_out, w_borrow_out;
    if (k == 0) begin : g_lsd
      assign w_carry_in  = 1'b1;
      assign w_borrow_in = 1'b1;
    end else begin : g_chain
      assign w_carry_in  = g_digit[k-1].w_carry_out;
      assign w_borrow_in = g_digit[k-1].w_borrow_out;
    end
    bcd_decade u_decade (
      .d_in       (r_bcd[4*k +: 4]),
      .up         (w_up),
      .dn         (w_dn),
      .carry_in   (w_carry_in),
      .borrow_in  (w_borrow_in),
      .d_out      (w_bcd_step[4*k +: 4]),
      .carry_out  (w_carry_out),
      .borrow_out (w_borrow_out)
    );
  end

  // A carry or borrow out of the top digit is the wrap/saturation boundary.
  assign w_ovf_evt = g_digit[NUM_DIGITS-1].w_carry_out | g_digit[NUM_DIGITS-1].w_borrow_out;
  assign w_hold    = ~WRAP & w_ovf_evt;
  assign w_change  = (w_up | w_dn) & ~w_hold;

  always_comb begin
    w_bin_next = r_bin;
    if (w_up)      w_bin_next = bcd_all9(ALL_W'(r_bcd), NUM_DIGITS) ? '0 : r_bin + CNT_W'(1);
    else if (w_dn) w_bin_next = (r_bin == '0) ? BIN_MAX : r_bin - CNT_W'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_change) begin
        r_bcd <= w_bcd_step;
        r_bin <= w_bin_next;
      end
      r_ovf <= r_ovf | w_ovf_evt;
    end
  end

  // The previous-cycle tx_start term keeps pulses at least two cycles apart.
  assign w_send = r_pending & ~tx_busy & ~r_tx_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_pending  <= clear | w_change | (r_pending & ~w_send);
      r_tx_start <= w_send;
      if (w_send) r_tx_data <= r_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_scan_idx <= '0;
    else if (scan_tick) r_scan_idx <= (r_scan_idx == SCAN_LAST) ? '0 : r_scan_idx + SCAN_W'(1);
  end

  always_comb begin
    scan_val = BCD_ZERO;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_scan_idx == SCAN_W'(k)) scan_val = r_bcd[4*k +: 4];
  end

`ifdef BCD_EVENT_COUNTER_LZ_BLANK_EN
  // Digit 0 is never blanked, so a zero count still shows a single "0".
  always_comb begin
    scan_blank = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (r_scan_idx == SCAN_W'(k)) scan_blank = ((r_bcd >> (4*k)) == '0);
  end
`else
  assign scan_blank = 1'b0;
`endif

  assign bcd       = r_bcd;
  assign bin_count = r_bin;
  assign overflow  = r_ovf;
  assign scan_idx  = r_scan_idx;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: directed boundary scenarios plus randomized traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_bcd_event_counter;
  import bcd_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-digit wrapping counter
  logic        a_inc, a_dec, a_clr, a_tick, a_busy;
  logic [31:0] a_bcd;
  logic [26:0] a_bin, a_txd;
  logic [2:0]  a_sidx;
  logic [3:0]  a_sval;
  logic        a_ovf, a_sblank, a_txs;

  // 2-digit pair sharing stimulus: wrapping (bw_) and saturating (bs_)
  logic        b_inc, b_dec, b_clr, b_tick, b_busy;
  logic [7:0]  bw_bcd, bs_bcd;
  logic [6:0]  bw_bin, bs_bin, bw_txd, bs_txd;
  logic [0:0]  bw_sidx, bs_sidx;
  logic [3:0]  bw_sval, bs_sval;
  logic        bw_ovf, bs_ovf, bw_sblank, bs_sblank, bw_txs, bs_txs;

  // 6-digit counter for the non-power-of-2 scan
  logic        c_inc, c_dec, c_clr, c_tick, c_busy;
  logic [23:0] c_bcd;
  logic [19:0] c_bin, c_txd;
  logic [2:0]  c_sidx;
  logic [3:0]  c_sval;
  logic        c_ovf, c_sblank, c_txs;

  bcd_event_counter #(.NUM_DIGITS(8), .CNT_W(27), .WRAP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .inc(a_inc), .dec(a_dec), .clear(a_clr), .scan_tick(a_tick),
    .tx_busy(a_busy), .bcd(a_bcd), .bin_count(a_bin), .overflow(a_ovf), .scan_idx(a_sidx),
    .scan_val(a_sval), .scan_blank(a_sblank), .tx_start(a_txs), .tx_data(a_txd));

  bcd_event_counter #(.NUM_DIGITS(2), .CNT_W(7), .WRAP(1'b1)) u_d2_wrap (
    .clk(clk), .rst_n(rst_n), .inc(b_inc), .dec(b_dec), .clear(b_clr), .scan_tick(b_tick),
    .tx_busy(b_busy), .bcd(bw_bcd), .bin_count(bw_bin), .overflow(bw_ovf), .scan_idx(bw_sidx),
    .scan_val(bw_sval), .scan_blank(bw_sblank), .tx_start(bw_txs), .tx_data(bw_txd));

  bcd_event_counter #(.NUM_DIGITS(2), .CNT_W(7), .WRAP(1'b0)) u_d2_sat (
    .clk(clk), .rst_n(rst_n), .inc(b_inc), .dec(b_dec), .clear(b_clr), .scan_tick(b_tick),
    .tx_busy(b_busy), .bcd(bs_bcd), .bin_count(bs_bin), .overflow(bs_ovf), .scan_idx(bs_sidx),
    .scan_val(bs_sval), .scan_blank(bs_sblank), .tx_start(bs_txs), .tx_data(bs_txd));

  bcd_event_counter #(.NUM_DIGITS(6), .CNT_W(20), .WRAP(1'b1)) u_d6 (
    .clk(clk), .rst_n(rst_n), .inc(c_inc), .dec(c_dec), .clear(c_clr), .scan_tick(c_tick),
    .tx_busy(c_busy), .bcd(c_bcd), .bin_count(c_bin), .overflow(c_ovf), .scan_idx(c_sidx),
    .scan_val(c_sval), .scan_blank(c_sblank), .tx_start(c_txs), .tx_data(c_txd));

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] to_bcd(input longint v, input int n);
    logic [31:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Next count from the decimal rules; evt = boundary hit, chg = value changed or cleared.
  function automatic longint mstep(input longint c, input int n, input bit wrap, input bit i,
                                   input bit d, input bit clr, output bit evt, output bit chg);
    longint top;
    top = pow10(n) - 1;
    evt = 1'b0;
    chg = 1'b0;
    if (clr) begin chg = 1'b1; return 0; end
    if (i && !d) begin
      if (c == top) begin evt = 1'b1; if (wrap) begin chg = 1'b1; return 0; end return c; end
      chg = 1'b1; return c + 1;
    end
    if (d && !i) begin
      if (c == 0) begin evt = 1'b1; if (wrap) begin chg = 1'b1; return top; end return c; end
      chg = 1'b1; return c - 1;
    end
    return c;
  endfunction

  function automatic bit exp_blank(input longint c, input int idx);
`ifdef BCD_EVENT_COUNTER_LZ_BLANK_EN
    return (idx != 0) && (c / pow10(idx) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_tests++; if (a_bcd !== 32'h0) begin n_fail++; $display("FAIL reset_bcd got %h exp 0", a_bcd); end
    n_tests++; if (a_bin !== 27'd0) begin n_fail++; $display("FAIL reset_bin got %0d exp 0", a_bin); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", a_ovf); end
    n_tests++; if (a_sidx !== 3'd0) begin n_fail++; $display("FAIL reset_sidx got %0d exp 0", a_sidx); end
    n_tests++; if (a_txs !== 1'b0) begin n_fail++; $display("FAIL reset_txs got %b exp 0", a_txs); end
    n_tests++; if (a_txd !== 27'd0) begin n_fail++; $display("FAIL reset_txd got %0d exp 0", a_txd); end
    n_tests++; if (a_sblank !== 1'b0) begin n_fail++; $display("FAIL reset_blank got %b exp 0", a_sblank); end
    n_tests++; if (c_sidx !== 3'd0) begin n_fail++; $display("FAIL reset_c_sidx got %0d exp 0", c_sidx); end
  endtask

  task automatic test_count_1234();
    a_inc = 1'b1;
    repeat (1234) cycle();
    a_inc = 1'b0;
    n_tests++; if (a_bcd !== 32'h00001234) begin n_fail++; $display("FAIL cnt1234_bcd got %h exp 00001234", a_bcd); end
    n_tests++; if (a_bin !== 27'd1234) begin n_fail++; $display("FAIL cnt1234_bin got %0d exp 1234", a_bin); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL cnt1234_ovf got %b exp 0", a_ovf); end
    idle(4);
    n_tests++; if (a_txd !== 27'd1234) begin n_fail++; $display("FAIL cnt1234_txd got %0d exp 1234", a_txd); end
  endtask

  task automatic test_wrap_2digit();
    int sat_starts, wrap_starts;
    b_clr = 1'b1; cycle(); b_clr = 1'b0;
    b_inc = 1'b1; repeat (99) cycle(); b_inc = 1'b0;
    idle(4);
    n_tests++; if (bw_bcd !== 8'h99) begin n_fail++; $display("FAIL w2_at99 got %h exp 99", bw_bcd); end
    n_tests++; if (bcd_all9(ALL_W'(bs_bcd), 2) !== 1'b1) begin n_fail++; $display("FAIL s2_at99 got %h exp 99", bs_bcd); end
    n_tests++; if (bs_ovf !== 1'b0) begin n_fail++; $display("FAIL s2_ovf_pre got %b exp 0", bs_ovf); end
    b_inc = 1'b1; cycle(); b_inc = 1'b0;
    n_tests++; if (bw_bcd !== 8'h00) begin n_fail++; $display("FAIL w2_wrap_bcd got %h exp 00", bw_bcd); end
    n_tests++; if (bw_bin !== 7'd0) begin n_fail++; $display("FAIL w2_wrap_bin got %0d exp 0", bw_bin); end
    n_tests++; if (bw_ovf !== 1'b1) begin n_fail++; $display("FAIL w2_wrap_ovf got %b exp 1", bw_ovf); end
    n_tests++; if (bs_bcd !== 8'h99) begin n_fail++; $display("FAIL s2_sat_bcd got %h exp 99", bs_bcd); end
    n_tests++; if (bs_bin !== 7'd99) begin n_fail++; $display("FAIL s2_sat_bin got %0d exp 99", bs_bin); end
    n_tests++; if (bs_ovf !== 1'b1) begin n_fail++; $display("FAIL s2_sat_ovf got %b exp 1", bs_ovf); end
    sat_starts = 0;
    wrap_starts = 0;
    repeat (4) begin
      if (bs_txs) sat_starts++;
      if (bw_txs) wrap_starts++;
      cycle();
    end
    n_tests++; if (sat_starts !== 0) begin n_fail++; $display("FAIL s2_sat_no_tx got %0d exp 0", sat_starts); end
    n_tests++; if (wrap_starts !== 1) begin n_fail++; $display("FAIL w2_wrap_tx got %0d exp 1", wrap_starts); end
    n_tests++; if (bw_txd !== 7'd0) begin n_fail++; $display("FAIL w2_wrap_txd got %0d exp 0", bw_txd); end
    b_clr = 1'b1; cycle(); b_clr = 1'b0;
    n_tests++; if (bw_ovf !== 1'b0 || bs_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b%b exp 00", bw_ovf, bs_ovf); end
    idle(4);
    b_dec = 1'b1; cycle(); b_dec = 1'b0;
    n_tests++; if (bw_bcd !== 8'h99) begin n_fail++; $display("FAIL w2_under_bcd got %h exp 99", bw_bcd); end
    n_tests++; if (bw_bin !== 7'd99) begin n_fail++; $display("FAIL w2_under_bin got %0d exp 99", bw_bin); end
    n_tests++; if (bw_ovf !== 1'b1) begin n_fail++; $display("FAIL w2_under_ovf got %b exp 1", bw_ovf); end
    n_tests++; if (bs_bcd !== 8'h00) begin n_fail++; $display("FAIL s2_under_bcd got %h exp 00", bs_bcd); end
    n_tests++; if (bs_ovf !== 1'b1) begin n_fail++; $display("FAIL s2_under_ovf got %b exp 1", bs_ovf); end
  endtask

  task automatic test_inc_dec_same();
    int starts;
    a_clr = 1'b1; cycle(); a_clr = 1'b0;
    a_inc = 1'b1; repeat (500) cycle(); a_inc = 1'b0;
    idle(4);
    a_inc = 1'b1; a_dec = 1'b1; cycle(); a_inc = 1'b0; a_dec = 1'b0;
    n_tests++; if (a_bcd !== 32'h00000500) begin n_fail++; $display("FAIL incdec_bcd got %h exp 00000500", a_bcd); end
    n_tests++; if (a_bin !== 27'd500) begin n_fail++; $display("FAIL incdec_bin got %0d exp 500", a_bin); end
    starts = 0;
    repeat (4) begin cycle(); if (a_txs) starts++; end
    n_tests++; if (starts !== 0) begin n_fail++; $display("FAIL incdec_no_tx got %0d exp 0", starts); end
  endtask

  task automatic test_coalesce();
    int starts;
    a_clr = 1'b1; cycle(); a_clr = 1'b0;
    a_inc = 1'b1; repeat (10) cycle(); a_inc = 1'b0;
    idle(4);
    a_busy = 1'b1;
    idle(1);
    starts = 0;
    a_inc = 1'b1;
    repeat (5) begin cycle(); if (a_txs) starts++; end
    a_inc = 1'b0;
    repeat (3) begin cycle(); if (a_txs) starts++; end
    n_tests++; if (starts !== 0) begin n_fail++; $display("FAIL busy_no_tx got %0d exp 0", starts); end
    n_tests++; if (a_bin !== 27'd15) begin n_fail++; $display("FAIL busy_bin got %0d exp 15", a_bin); end
    a_busy = 1'b0;
    cycle();
    n_tests++; if (a_txs !== 1'b1) begin n_fail++; $display("FAIL release_tx got %b exp 1", a_txs); end
    n_tests++; if (a_txd !== 27'd15) begin n_fail++; $display("FAIL release_txd got %0d exp 15", a_txd); end
    starts = 0;
    repeat (4) begin cycle(); if (a_txs) starts++; end
    n_tests++; if (starts !== 0) begin n_fail++; $display("FAIL release_single got %0d extra exp 0", starts); end
  endtask

  task automatic test_scan();
    int exp_idx;
    c_clr = 1'b1; cycle(); c_clr = 1'b0;
    c_inc = 1'b1; repeat (42) cycle(); c_inc = 1'b0;
    idle(2);
    n_tests++; if (c_bcd !== 24'h000042) begin n_fail++; $display("FAIL scan_cnt got %h exp 000042", c_bcd); end
    n_tests++; if (c_sidx !== 3'd0) begin n_fail++; $display("FAIL scan_hold got %0d exp 0", c_sidx); end
    for (int i = 1; i <= 6; i++) begin
      c_tick = 1'b1; cycle(); c_tick = 1'b0;
      exp_idx = i % 6;
      n_tests++; if (c_sidx !== 3'(exp_idx)) begin n_fail++; $display("FAIL scan_idx got %0d exp %0d", c_sidx, exp_idx); end
      n_tests++; if (c_sval !== 4'((42 / pow10(exp_idx)) % 10)) begin n_fail++; $display("FAIL scan_val idx %0d got %0d", exp_idx, c_sval); end
      n_tests++; if (c_sblank !== exp_blank(42, exp_idx)) begin n_fail++; $display("FAIL scan_blank idx %0d got %b exp %b", exp_idx, c_sblank, exp_blank(42, exp_idx)); end
    end
  endtask

  task automatic test_random();
    longint ma, ma_old, mbw, mbs;
    bit     ma_ovf, mbw_ovf, mbs_ovf, evt, chg_a, chg_b, unsent, prev_txs, busy_applied;
    bit     ai, ad, ac, at, bi, bd, bc;
    int     ma_idx;
    logic [26:0] last_txd;
    a_clr = 1'b1; b_clr = 1'b1; cycle(); a_clr = 1'b0; b_clr = 1'b0;
    ma = 0; mbw = 0; mbs = 0;
    ma_ovf = 1'b0; mbw_ovf = 1'b0; mbs_ovf = 1'b0;
    ma_idx = 0;
    unsent = 1'b1;
    prev_txs = a_txs;
    last_txd = a_txd;
    for (int n = 0; n < 3000; n++) begin
      ac = ($urandom % 64) == 0;
      ai = ($urandom % 3) == 0;
      ad = ($urandom % 3) == 0;
      at = $urandom % 2;
      bc = ($urandom % 128) == 0;
      bi = ($urandom % 2) == 0;
      bd = ($urandom % 2) == 0;
      if (($urandom % 4) == 0) a_busy = ~a_busy;
      a_clr = ac; a_inc = ai; a_dec = ad; a_tick = at;
      b_clr = bc; b_inc = bi; b_dec = bd;
      busy_applied = a_busy;
      ma_old = ma;
      cycle();
      ma = mstep(ma, 8, 1'b1, ai, ad, ac, evt, chg_a);
      ma_ovf = ac ? 1'b0 : (ma_ovf | evt);
      if (at) ma_idx = (ma_idx + 1) % 8;
      mbw = mstep(mbw, 2, 1'b1, bi, bd, bc, evt, chg_b);
      mbw_ovf = bc ? 1'b0 : (mbw_ovf | evt);
      mbs = mstep(mbs, 2, 1'b0, bi, bd, bc, evt, chg_b);
      mbs_ovf = bc ? 1'b0 : (mbs_ovf | evt);
      n_tests++; if (a_bcd !== to_bcd(ma, 8)) begin n_fail++; $display("FAIL rnd_bcd cyc %0d got %h exp %h", n, a_bcd, to_bcd(ma, 8)); end
      n_tests++; if (a_bin !== 27'(ma)) begin n_fail++; $display("FAIL rnd_bin cyc %0d got %0d exp %0d", n, a_bin, ma); end
      n_tests++; if (a_ovf !== ma_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", n, a_ovf, ma_ovf); end
      n_tests++; if (a_sidx !== 3'(ma_idx)) begin n_fail++; $display("FAIL rnd_sidx cyc %0d got %0d exp %0d", n, a_sidx, ma_idx); end
      n_tests++; if (a_sval !== 4'((ma / pow10(ma_idx)) % 10)) begin n_fail++; $display("FAIL rnd_sval cyc %0d got %0d", n, a_sval); end
      n_tests++; if (a_sblank !== exp_blank(ma, ma_idx)) begin n_fail++; $display("FAIL rnd_blank cyc %0d got %b", n, a_sblank); end
      if (a_txs) begin
        n_tests++; if (prev_txs !== 1'b0 || busy_applied !== 1'b0 || unsent !== 1'b1) begin n_fail++; $display("FAIL rnd_tx_cond cyc %0d prev %b busy %b unsent %b exp 0 0 1", n, prev_txs, busy_applied, unsent); end
        n_tests++; if (a_txd !== 27'(ma_old)) begin n_fail++; $display("FAIL rnd_txd cyc %0d got %0d exp %0d", n, a_txd, ma_old); end
      end else begin
        n_tests++; if (a_txd !== last_txd) begin n_fail++; $display("FAIL rnd_txd_hold cyc %0d got %0d exp %0d", n, a_txd, last_txd); end
      end
      unsent = (unsent & ~a_txs) | chg_a;
      prev_txs = a_txs;
      last_txd = a_txd;
      n_tests++; if (bw_bcd !== 8'(to_bcd(mbw, 2)) || bw_bin !== 7'(mbw) || bw_ovf !== mbw_ovf) begin n_fail++; $display("FAIL rnd_w2 cyc %0d got %h/%0d/%b exp %0d/%b", n, bw_bcd, bw_bin, bw_ovf, mbw, mbw_ovf); end
      n_tests++; if (bs_bcd !== 8'(to_bcd(mbs, 2)) || bs_bin !== 7'(mbs) || bs_ovf !== mbs_ovf) begin n_fail++; $display("FAIL rnd_s2 cyc %0d got %h/%0d/%b exp %0d/%b", n, bs_bcd, bs_bin, bs_ovf, mbs, mbs_ovf); end
    end
    a_clr = 1'b0; a_inc = 1'b0; a_dec = 1'b0; a_tick = 1'b0; a_busy = 1'b0;
    b_clr = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
    repeat (6) begin cycle(); if (a_txs) unsent = 1'b0; end
    n_tests++; if (unsent !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got unsent %b exp 0", unsent); end
    n_tests++; if (a_txd !== 27'(ma)) begin n_fail++; $display("FAIL rnd_drain_txd got %0d exp %0d", a_txd, ma); end
  endtask

  task automatic test_reset_mid();
    int starts;
    a_busy = 1'b1;
    a_clr = 1'b1; cycle(); a_clr = 1'b0;
    a_inc = 1'b1; repeat (77) cycle(); a_inc = 1'b0;
    cycle();
    n_tests++; if (a_bin !== 27'd77) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 77", a_bin); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (a_bcd !== 32'h0 || a_bin !== 27'd0) begin n_fail++; $display("FAIL rstmid_cnt got %h/%0d exp 0/0", a_bcd, a_bin); end
    n_tests++; if (a_ovf !== 1'b0 || a_sidx !== 3'd0) begin n_fail++; $display("FAIL rstmid_flags got %b/%0d exp 0/0", a_ovf, a_sidx); end
    n_tests++; if (a_txs !== 1'b0 || a_txd !== 27'd0) begin n_fail++; $display("FAIL rstmid_tx got %b/%0d exp 0/0", a_txs, a_txd); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_busy = 1'b0;
    starts = 0;
    repeat (6) begin cycle(); if (a_txs) starts++; end
    n_tests++; if (starts !== 0) begin n_fail++; $display("FAIL rstmid_no_tx got %0d exp 0", starts); end
    n_tests++; if (a_bcd !== 32'h0) begin n_fail++; $display("FAIL rstmid_post got %h exp 0", a_bcd); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_inc = 1'b0; a_dec = 1'b0; a_clr = 1'b0; a_tick = 1'b0; a_busy = 1'b0;
    b_inc = 1'b0; b_dec = 1'b0; b_clr = 1'b0; b_tick = 1'b0; b_busy = 1'b0;
    c_inc = 1'b0; c_dec = 1'b0; c_clr = 1'b0; c_tick = 1'b0; c_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_count_1234();
    test_wrap_2digit();
    test_inc_dec_same();
    test_coalesce();
    test_scan();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
